// File: rtl/spi_master.sv
// spi_master: SPI mode-0 master (CPOL=0, CPHA=0), MSB first, 8-bit frames with SSEL-held bursts
// Ports: clk/PRESET clock and synchronous active-high reset; Tx_byte_data, data_in_val, hold_ssel
// request side; MISO in, MOSI/SCK/SSEL serial out; tx_ready, busy, byte_data_received and the
// data_out_ready pulse report status. All outputs are registered.
module spi_master #(
  parameter int CLK_DIV    = 4,
  parameter int SSEL_SETUP = 4,
  parameter int SSEL_IDLE  = 4
) (
  input  logic       clk,
  input  logic       PRESET,
  input  logic [7:0] Tx_byte_data,
  input  logic       data_in_val,
  input  logic       hold_ssel,
  input  logic       MISO,
  output logic       MOSI,
  output logic       SCK,
  output logic       SSEL,
  output logic       tx_ready,
  output logic [7:0] byte_data_received,
  output logic       data_out_ready,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, SETUP, SCK_LO, SCK_HI, HOLD, WAIT_NEXT, GAP} state_t;
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d, len, tx_q, tx_d, rx_q, rx_d, rbyte_q, rbyte_d;
  logic [2:0] bit_q, bit_d;
  logic [1:0] miso_q;
  logic       mosi_q, mosi_d, dor_q, dor_d, sck_q, ssel_q, rdy_q, busy_q, last;
  always_comb begin
    len = state_q == SETUP ? 8'(SSEL_SETUP) : state_q == GAP ? 8'(SSEL_IDLE) : 8'(CLK_DIV);
    last = cnt_q == len - 8'd1;
    state_d = state_q;
    bit_d = bit_q;
    tx_d = tx_q;
    rx_d = rx_q;
    mosi_d = mosi_q;
    rbyte_d = rbyte_q;
    dor_d = 1'b0;
    case (state_q)
      IDLE: if (data_in_val) begin
        tx_d = Tx_byte_data;
        bit_d = 3'd0;
        mosi_d = Tx_byte_data[7];
        state_d = SETUP;
      end
      SETUP: if (last) state_d = SCK_LO;
      SCK_LO: if (last) state_d = SCK_HI;
      SCK_HI: begin
        // miso_q[1] is the pin value two clk earlier, stable since mid low phase
        if (cnt_q == 8'd0) rx_d = {rx_q[6:0], miso_q[1]};
        if (last && bit_q != 3'd7) begin
          bit_d = bit_q + 3'd1;
          tx_d = {tx_q[6:0], 1'b0};
          mosi_d = tx_q[6];
          state_d = SCK_LO;
        end else if (last) begin
          rbyte_d = rx_q;
          dor_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: if (last) begin
        state_d = hold_ssel ? WAIT_NEXT : GAP;
        mosi_d = hold_ssel & mosi_q;
      end
      WAIT_NEXT: if (data_in_val) begin
        tx_d = Tx_byte_data;
        bit_d = 3'd0;
        mosi_d = Tx_byte_data[7];
        state_d = SCK_LO;
      end else if (!hold_ssel) begin
        mosi_d = 1'b0;
        state_d = GAP;
      end
      GAP: if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cnt_d = (state_d != state_q || state_q == IDLE || state_q == WAIT_NEXT) ? 8'd0 : cnt_q + 8'd1;
  end
  always_ff @(posedge clk) begin
    if (PRESET) begin
      state_q <= IDLE;
      cnt_q <= 8'd0;
      bit_q <= 3'd0;
      tx_q <= 8'd0;
      rx_q <= 8'd0;
      rbyte_q <= 8'd0;
      miso_q <= 2'd0;
      mosi_q <= 1'b0;
      dor_q <= 1'b0;
      sck_q <= 1'b0;
      ssel_q <= 1'b1;
      rdy_q <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
      rbyte_q <= rbyte_d;
      miso_q <= {miso_q[0], MISO};
      mosi_q <= mosi_d;
      dor_q <= dor_d;
      sck_q <= state_d == SCK_HI;
      ssel_q <= state_d == IDLE || state_d == GAP;
      rdy_q <= state_d == IDLE || state_d == WAIT_NEXT;
      busy_q <= state_d != IDLE;
    end
  end
  assign MOSI = mosi_q;
  assign SCK = sck_q;
  assign SSEL = ssel_q;
  assign tx_ready = rdy_q;
  assign byte_data_received = rbyte_q;
  assign data_out_ready = dor_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: random scoreboard bench for spi_master against a behavioural SPI slave and a loopback
module tb_spi_master;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask
  logic       a_rst = 1'b1, a_dv = 1'b0, a_hold = 1'b0, a_miso = 1'b0;
  logic [7:0] a_tx = 8'd0, a_rb;
  logic       a_mosi, a_sck, a_ssel, a_rdy, a_dor, a_busy;
  spi_master dut_a (
    .clk(clk), .PRESET(a_rst), .Tx_byte_data(a_tx), .data_in_val(a_dv), .hold_ssel(a_hold),
    .MISO(a_miso), .MOSI(a_mosi), .SCK(a_sck), .SSEL(a_ssel), .tx_ready(a_rdy),
    .byte_data_received(a_rb), .data_out_ready(a_dor), .busy(a_busy)
  );
  logic       b_rst = 1'b1, b_dv = 1'b0, b_hold = 1'b0;
  logic [7:0] b_tx = 8'd0, b_rb;
  logic       b_mosi, b_sck, b_ssel, b_rdy, b_dor, b_busy;
  spi_master #(.CLK_DIV(6), .SSEL_SETUP(1), .SSEL_IDLE(4)) dut_b (
    .clk(clk), .PRESET(b_rst), .Tx_byte_data(b_tx), .data_in_val(b_dv), .hold_ssel(b_hold),
    .MISO(b_mosi), .MOSI(b_mosi), .SCK(b_sck), .SSEL(b_ssel), .tx_ready(b_rdy),
    .byte_data_received(b_rb), .data_out_ready(b_dor), .busy(b_busy)
  );
  logic [7:0] exp_mosi[$], exp_rx[$];
  int         exp_cyc[$];
  logic [7:0] s_cur = 8'd0, s_rx = 8'd0;
  int         s_bit = 0;
  logic       p_sck = 1'b0, p_ssel = 1'b1;
  always @(negedge clk) begin
    if (p_ssel && !a_ssel) begin
      s_cur = 8'($urandom);
      s_bit = 0;
      a_miso = s_cur[7];
    end
    if (a_ssel) s_bit = 0;
    if (!a_ssel && !p_sck && a_sck) begin
      s_rx = {s_rx[6:0], a_mosi};
      s_bit++;
      if (s_bit == 8) begin
        s_bit = 0;
        exp_rx.push_back(s_cur);
        if (exp_mosi.size() == 0) chk("slave_unexpected_byte", 1, 0);
        else chk("slave_rx", s_rx, exp_mosi.pop_front());
        s_cur = 8'($urandom);
      end
    end
    if (!a_ssel && p_sck && !a_sck) a_miso = s_cur[7 - s_bit];
    p_sck = a_sck;
    p_ssel = a_ssel;
  end
  always @(negedge clk) if (a_dor) begin
    if (exp_cyc.size() == 0 || exp_rx.size() == 0) chk("dor_unexpected", 1, 0);
    else begin
      chk("dor_cycle", cyc, exp_cyc.pop_front());
      chk("master_rx", a_rb, exp_rx.pop_front());
    end
  end
  int a_hi = 0, b_hi = 0;
  always @(negedge clk) begin
    if (a_sck === 1'b1) a_hi++;
    else if (a_hi != 0) begin
      chk("sckA_high_len", a_hi, 4);
      a_hi = 0;
    end
    if (b_sck === 1'b1) b_hi++;
    else if (b_hi != 0) begin
      chk("sckB_high_len", b_hi, 6);
      b_hi = 0;
    end
  end
  logic [7:0] dir_b[3];
  task automatic junk();
    a_dv = 1'($urandom);
    a_tx = 8'($urandom);
  endtask
  task automatic send(input int n, input bit rnd);
    int t0 = 0, low = 0, w;
    for (int k = 0; k < n; k++) begin
      w = 0;
      while (!a_rdy && w < 400) begin
        if (!a_ssel) low++;
        junk();
        @(negedge clk);
        w++;
      end
      if (w >= 400) chk("ready_timeout", 0, 1);
      a_tx = rnd ? 8'($urandom) : dir_b[k];
      a_dv = 1'b1;
      a_hold = k < n - 1;
      exp_mosi.push_back(a_tx);
      exp_cyc.push_back(cyc + (k == 0 ? 69 : 65));
      if (k == 0) t0 = cyc;
      @(negedge clk);
      a_dv = 1'b0;
      a_tx = 8'($urandom);
    end
    w = 0;
    while (!a_rdy && w < 400) begin
      if (!a_ssel) low++;
      junk();
      @(negedge clk);
      w++;
    end
    a_dv = 1'b0;
    if (w >= 400) chk("ready_timeout", 0, 1);
    chk("frame_len", cyc - t0, 77 + 69 * (n - 1));
    chk("ssel_low_cycles", low, 72 + 68 * (n - 1));
    chk("busy_at_ready", a_busy, 0);
  endtask
  task automatic reset_mid_frame();
    int t0;
    while (!a_rdy) @(negedge clk);
    a_tx = 8'($urandom);
    a_dv = 1'b1;
    t0 = cyc;
    @(negedge clk);
    a_dv = 1'b0;
    chk("busy_in_frame", a_busy, 1);
    chk("ssel_in_frame", a_ssel, 0);
    while (cyc < t0 + 30) @(negedge clk);
    a_rst = 1'b1;
    @(negedge clk);
    a_rst = 1'b0;
    chk("rst_ssel", a_ssel, 1);
    chk("rst_sck", a_sck, 0);
    chk("rst_mosi", a_mosi, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_dor", a_dor, 0);
    chk("rst_ready", a_rdy, 1);
    chk("rst_rbyte", a_rb, 0);
    exp_mosi.delete();
    repeat (100) @(negedge clk);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int t0, w, nd;
    logic [7:0] bt;
    repeat (3) @(negedge clk);
    chk("reset_ready", a_rdy, 1);
    chk("reset_ssel", a_ssel, 1);
    chk("reset_sck", a_sck, 0);
    chk("reset_mosi", a_mosi, 0);
    chk("reset_busy", a_busy, 0);
    chk("reset_dor", a_dor, 0);
    chk("reset_rbyte", a_rb, 0);
    a_rst = 1'b0;
    @(negedge clk);
    dir_b = '{8'hA5, 8'h00, 8'h00};
    send(1, 1'b0);
    repeat (3) @(negedge clk);
    dir_b = '{8'h01, 8'h80, 8'hFF};
    send(3, 1'b0);
    reset_mid_frame();
    for (int i = 0; i < 12; i++) begin
      send(int'($urandom_range(1, 3)), 1'b1);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    chk("scoreboard_drained", exp_cyc.size() + exp_rx.size() + exp_mosi.size(), 0);
    b_rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      w = 0;
      while (!b_rdy && w < 400) begin
        @(negedge clk);
        w++;
      end
      bt = i == 0 ? 8'h3C : 8'($urandom);
      b_tx = bt;
      b_dv = 1'b1;
      t0 = cyc;
      @(negedge clk);
      b_dv = 1'b0;
      b_tx = 8'($urandom);
      nd = 0;
      w = 0;
      while (!b_rdy && w < 400) begin
        if (b_dor) begin
          nd++;
          chk("b_dor_cycle", cyc, t0 + 98);
          chk("b_loopback", b_rb, bt);
        end
        @(negedge clk);
        w++;
      end
      chk("b_frame_len", cyc - t0, 108);
      chk("b_dor_count", nd, 1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
